// File: rtl/mem_access_unit.sv
// Sequences one CPU data access (lw/lb/lbu/lh/lhu, sw/sb/sh) against a combinational-read memory.
// Latency: load READ_WAIT+1, word store 2, sub-word store READ_WAIT+2, misaligned 1 cycle after req.
// Backpressure: req is only sampled in IDLE; requests in any other state are ignored.
module mem_access_unit #(
    parameter int unsigned READ_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        misalign,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_write_data_src,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned   WCW       = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RMW_RD,
        S_RMW_WR,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WCW-1:0]  wait_cnt;
    logic            wait_done;
    logic [1:0]      size_q;
    logic            sext_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     data_q;
    logic            req_mis;
    logic            req_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_val;
    logic [31:0]     merged;

    // Byte accesses are never misaligned; size 11 behaves as a word.
    assign req_word  = (size[1] == size[0]);
    assign req_mis   = (size == 2'b10) ? addr[0] : (req_word && (addr[1:0] != 2'b00));
    assign wait_done = (wait_cnt == WAIT_LAST);

    assign mem_addr           = {addr_q[31:2], 2'b00};
    assign mem_write_data_src = 2'b00;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore control outputs.
    always_comb begin
        state_nxt = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ready     = 1'b0;
        misalign  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_mis)       state_nxt = S_ERR;
                    else if (!we)      state_nxt = S_RD;
                    else if (req_word) state_nxt = S_WR;
                    else               state_nxt = S_RMW_RD;
                end
            end
            S_RD: begin
                mem_read = 1'b1;
                if (wait_done) state_nxt = S_DONE;
            end
            S_RMW_RD: begin
                mem_read = 1'b1;
                if (wait_done) state_nxt = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_write = 1'b1;
                state_nxt = S_DONE;
            end
            S_WR: begin
                mem_write = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                ready     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                ready     = 1'b1;
                misalign  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wait-state counter: runs only while a read is outstanding, wraps on the sampling cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (mem_read) begin
            wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Request latch: captured once in IDLE so mem_addr stays stable for the whole access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == S_IDLE && req) begin
            size_q  <= size;
            sext_q  <= sign_ext;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Load lane extraction and extension from the word arriving on the last wait cycle.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_q[1:0])
            2'd0: ld_byte = mem_read_data[7:0];
            2'd1: ld_byte = mem_read_data[15:8];
            2'd2: ld_byte = mem_read_data[23:16];
            default: ld_byte = mem_read_data[31:24];
        endcase
        ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b01:   ld_val = {{24{sext_q & ld_byte[7]}}, ld_byte};
            2'b10:   ld_val = {{16{sext_q & ld_half[15]}}, ld_half};
            default: ld_val = mem_read_data;
        endcase
    end

    // Read-data capture; rdata only moves when a load heads into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            rdata  <= '0;
        end else begin
            if (mem_read && wait_done) data_q <= mem_read_data;
            if (state == S_RD && wait_done) rdata <= ld_val;
        end
    end

    // Store merge: replace the addressed lane(s) of the word read back in RMW_RD.
    always_comb begin
        merged = data_q;
        case (size_q)
            2'b01: begin
                case (addr_q[1:0])
                    2'd0: merged[7:0]   = wdata_q[7:0];
                    2'd1: merged[15:8]  = wdata_q[7:0];
                    2'd2: merged[23:16] = wdata_q[7:0];
                    default: merged[31:24] = wdata_q[7:0];
                endcase
            end
            2'b10: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = data_q;
        endcase
    end

    // Write data is only driven in the write states so the bus idles at zero.
    always_comb begin
        mem_write_data = '0;
        if (state == S_WR)          mem_write_data = wdata_q;
        else if (state == S_RMW_WR) mem_write_data = merged;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random accesses against a word-array model.
// Latency: checked per access against the cycle counts of each access class.
// Backpressure: req is raised only while the unit is idle, except in the held-req case.
module tb_mem_access_unit;

    localparam int RW = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, mem_addr, mem_write_data, mem_read_data;
    logic        ready, misalign, mem_read, mem_write;
    logic [1:0]  mem_write_data_src;

    logic        req_b, we_b, sign_ext_b;
    logic [1:0]  size_b;
    logic [31:0] addr_b, wdata_b;
    logic [31:0] rdata_b, mem_addr_b, mem_write_data_b, mem_read_data_b;
    logic        ready_b, misalign_b, mem_read_b, mem_write_b;
    logic [1:0]  mem_write_data_src_b;

    logic [31:0] mem     [0:15];
    logic [31:0] ref_mem [0:15];
    logic [31:0] ref_rdata;
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_dat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_WAIT(RW)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .misalign(misalign),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_write_data_src(mem_write_data_src),
        .mem_read_data(mem_read_data)
    );

    mem_access_unit #(.READ_WAIT(1)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .size(size_b), .sign_ext(sign_ext_b),
        .addr(addr_b), .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .misalign(misalign_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
        .mem_write_data(mem_write_data_b), .mem_write_data_src(mem_write_data_src_b),
        .mem_read_data(mem_read_data_b)
    );

    // Memory: combinational read, write on the clock edge; preload port for the bench.
    assign mem_read_data   = mem[mem_addr[5:2]];
    assign mem_read_data_b = mem_read_b ? 32'hA5C3_0F96 : 32'h0;

    always @(posedge clk) begin
        if (pre_we)         mem[pre_idx] <= pre_dat;
        else if (mem_write) mem[mem_addr[5:2]] <= mem_write_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b01) return 1'b0;
        if (sz == 2'b10) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        if (sz == 2'b01) begin
            sh = 8 * int'(a[1:0]);
            v  = (w >> sh) & 32'hFF;
            if (sx && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b10) begin
            sh = 16 * int'(a[1]);
            v  = (w >> sh) & 32'hFFFF;
            if (sx && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        int sh;
        if (sz == 2'b01) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'hFF << sh;
            return (w & ~m) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b10) begin
            sh = 16 * int'(a[1]);
            m  = 32'hFFFF << sh;
            return (w & ~m) | ((wd & 32'hFFFF) << sh);
        end
        return wd;
    endfunction

    task automatic poke(input int idx, input logic [31:0] d);
        pre_idx = 4'(idx);
        pre_dat = d;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Drives one request and watches the bus until ready (bounded).
    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd, input bit hold,
                              output int lat, output int rdc, output int wrc,
                              output int bad, output logic mis_seen);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        lat = -1; rdc = 0; wrc = 0; bad = 0; mis_seen = 1'b0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (!hold) req = 1'b0;
            if (mem_read)  rdc++;
            if (mem_write) wrc++;
            if (mem_read && mem_write) bad = bad | 1;
            if ((mem_read || mem_write) && mem_addr !== {a[31:2], 2'b00}) bad = bad | 2;
            if (mem_write && mem_write_data_src !== 2'b00) bad = bad | 4;
            if (ready) begin
                lat = i;
                mis_seen = misalign;
            end
        end
    endtask

    task automatic do_access(input string tag, input logic w, input logic [1:0] sz,
                             input logic sx, input logic [31:0] a, input logic [31:0] wd);
        int idx, lat, rdc, wrc, bad, exp_lat, exp_rd, exp_wr;
        logic mis_seen;
        bit mis, sub;
        logic [31:0] exp_word;
        idx = int'(a[5:2]);
        mis = ref_mis(sz, a);
        sub = (sz == 2'b01) || (sz == 2'b10);
        exp_word = ref_mem[idx];
        if (mis) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0;
        end else if (!w) begin
            exp_lat = RW + 1; exp_rd = RW; exp_wr = 0;
            ref_rdata = ref_load(ref_mem[idx], sz, sx, a);
        end else if (!sub) begin
            exp_lat = 2; exp_rd = 0; exp_wr = 1;
            exp_word = wd;
        end else begin
            exp_lat = RW + 2; exp_rd = RW; exp_wr = 1;
            exp_word = ref_store(ref_mem[idx], sz, a, wd);
        end
        @(negedge clk);
        run_access(w, sz, sx, a, wd, 1'b0, lat, rdc, wrc, bad, mis_seen);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_mis"},   32'(mis_seen), 32'(mis));
        check({tag, "_rdcyc"}, 32'(rdc), 32'(exp_rd));
        check({tag, "_wrcyc"}, 32'(wrc), 32'(exp_wr));
        check({tag, "_bus"},   32'(bad), 32'd0);
        check({tag, "_rdata"}, rdata, ref_rdata);
        check({tag, "_mem"},   mem[idx], exp_word);
        ref_mem[idx] = exp_word;
    endtask

    // Reset asserted two cycles into a read phase; nothing may reach memory.
    task automatic reset_mid(input string tag, input logic w, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        int idx;
        idx = int'(a[5:2]);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = 1'b0; addr = a; wdata = wd;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check({tag, "_inrd"}, 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        ref_rdata = 32'h0;
        check({tag, "_rd0"},   32'(mem_read), 32'd0);
        check({tag, "_wr0"},   32'(mem_write), 32'd0);
        check({tag, "_rdy0"},  32'(ready), 32'd0);
        check({tag, "_addr0"}, mem_addr, 32'h0);
        check({tag, "_rdata0"}, rdata, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (RW + 3) begin
            @(negedge clk);
            if (ready || mem_write) check({tag, "_quiet"}, {30'b0, ready, mem_write}, 32'h0);
        end
        check({tag, "_memkeep"}, mem[idx], ref_mem[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int lat, rdc, wrc, bad, lat_b, rdc_b, wrc_b;
        logic mis_seen;
        logic [31:0] ra, rwd;
        logic [1:0]  rsz;
        logic        rw, rsx;

        reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; pre_we = 1'b0; pre_idx = '0; pre_dat = '0;
        req_b = 1'b0; we_b = 1'b0; size_b = 2'b00; sign_ext_b = 1'b0;
        addr_b = 32'h10; wdata_b = '0;
        ref_rdata = 32'h0;

        for (int i = 0; i < 16; i++) poke(i, $urandom);
        @(negedge clk);
        check("rst_rdata",  rdata, 32'h0);
        check("rst_ready",  32'(ready), 32'd0);
        check("rst_mis",    32'(misalign), 32'd0);
        check("rst_mrd",    32'(mem_read), 32'd0);
        check("rst_mwr",    32'(mem_write), 32'd0);
        check("rst_maddr",  mem_addr, 32'h0);
        check("rst_mwdata", mem_write_data, 32'h0);
        check("rst_src",    32'(mem_write_data_src), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        poke(4, 32'hDEAD_BEEF);
        do_access("lw10", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("lw10_abs", rdata, 32'hDEAD_BEEF);
        do_access("lb13", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
        check("lb13_abs", rdata, 32'hFFFF_FFDE);
        do_access("lbu13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
        check("lbu13_abs", rdata, 32'h0000_00DE);
        do_access("lh12", 1'b0, 2'b10, 1'b1, 32'h12, 32'h0);
        check("lh12_abs", rdata, 32'hFFFF_DEAD);
        do_access("lhu10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lhu10_abs", rdata, 32'h0000_BEEF);

        poke(4, 32'h1122_3344);
        do_access("sb11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h55);
        check("sb11_abs", mem[4], 32'h1122_5544);
        do_access("sh12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hABCD);
        check("sh12_abs", mem[4], 32'hABCD_5544);

        do_access("lw0e", 1'b0, 2'b00, 1'b0, 32'h0E, 32'h0);
        do_access("sh13", 1'b1, 2'b10, 1'b0, 32'h13, 32'h1234);
        check("mis_keep", mem[4], 32'hABCD_5544);

        reset_mid("rst_rd",  1'b0, 2'b00, 32'h10, 32'h0);
        reset_mid("rst_rmw", 1'b1, 2'b01, 32'h11, 32'h99);
        do_access("lw_after", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("lw_after_abs", rdata, 32'hABCD_5544);

        // Held req: the second load starts in the IDLE cycle right after DONE.
        @(negedge clk);
        run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, lat, rdc, wrc, bad, mis_seen);
        check("hold1_lat", 32'(lat), 32'(RW + 1));
        check("hold1_rd",  32'(rdc), 32'(RW));
        run_access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1, lat, rdc, wrc, bad, mis_seen);
        req = 1'b0;
        ref_rdata = ref_load(ref_mem[4], 2'b01, 1'b1, 32'h12);
        check("hold2_lat",   32'(lat), 32'(RW + 2));
        check("hold2_rd",    32'(rdc), 32'(RW));
        check("hold2_wr",    32'(wrc), 32'd0);
        check("hold2_rdata", rdata, ref_rdata);

        for (int n = 0; n < 40; n++) begin
            ra  = 32'($urandom_range(0, 63));
            rsz = 2'($urandom_range(0, 3));
            rw  = 1'($urandom_range(0, 1));
            rsx = 1'($urandom_range(0, 1));
            rwd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (rsz == 2'b10)      ra[0] = 1'b0;
                else if (rsz != 2'b01) ra[1:0] = 2'b00;
            end
            do_access($sformatf("rnd%0d", n), rw, rsz, rsx, ra, rwd);
        end

        // READ_WAIT=1 build: load ready two cycles after the request edge.
        @(negedge clk);
        req_b = 1'b1;
        lat_b = -1; rdc_b = 0; wrc_b = 0;
        for (int i = 1; i <= 10 && lat_b < 0; i++) begin
            @(negedge clk);
            req_b = 1'b0;
            if (mem_read_b) begin
                rdc_b++;
                check("b_addr", mem_addr_b, 32'h10);
            end
            if (mem_write_b) wrc_b++;
            if (ready_b) begin
                lat_b = i;
                check("b_mis",   32'(misalign_b), 32'd0);
                check("b_wdata", mem_write_data_b, 32'h0);
                check("b_src",   32'(mem_write_data_src_b), 32'd0);
            end
        end
        check("b_lat",   32'(lat_b), 32'd2);
        check("b_rdcyc", 32'(rdc_b), 32'd1);
        check("b_wrcyc", 32'(wrc_b), 32'd0);
        check("b_rdata", rdata_b, 32'hA5C3_0F96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
